// File: rtl/hyb_ssd_pkg.sv
// Shared constants, types and the hex-to-segment decoder for the hybrid cipher display pager.
package hyb_ssd_pkg;

  typedef enum logic {EMPTY, LOADED} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry d drives digit d. Codes are {a,b,c,d,e,f,g} and active-low.
  localparam logic [7:0][6:0] HYB_BANNER = {
    7'b1100000, 7'b0111000, 7'b0010010, 7'b1111110,
    7'b1001111, 7'b0001000, 7'b0110000, 7'b0100100
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0:    return 7'b0000001;
      4'h1:    return 7'b1001111;
      4'h2:    return 7'b0010010;
      4'h3:    return 7'b0000110;
      4'h4:    return 7'b1001100;
      4'h5:    return 7'b0100100;
      4'h6:    return 7'b0100000;
      4'h7:    return 7'b0001111;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0000100;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b1100000;
      4'hC:    return 7'b0110001;
      4'hD:    return 7'b1000010;
      4'hE:    return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

endpackage

// File: rtl/hyb_ssd_pager_debounce.sv
// Button conditioner: two-flop synchroniser, stable-sample counter and a one-cycle rise pulse.
module hyb_debounce #(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync1 -> sync2 a true two-stage shift.
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
        level <= sync2;
        press <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hyb_ssd_pager.sv
// Paged seven-segment viewer for a captured cipher word. Optional digit scanning: HYB_SSD_SCAN_EN.
module hyb_ssd_pager
  import hyb_ssd_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int DIGITS   = 8,
  parameter int DEBOUNCE = 16,
`ifdef HYB_SSD_SCAN_EN
  parameter int SCAN_DIV = 50000,
`endif
  localparam int PAGES  = DATA_W / (4 * DIGITS),
  localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  input  logic                disp,
  input  logic                btn_next,
  input  logic                btn_prev,
`ifdef HYB_SSD_SCAN_EN
  output logic [6:0]          seg_out,
  output logic [DIGITS-1:0]   an_out,
`else
  output logic [7*DIGITS-1:0] seg_out,
`endif
  output logic [PAGE_W-1:0]   page,
  output logic                loaded
);

  state_t               state;
  logic [DATA_W-1:0]    hold;
  logic [7*DIGITS-1:0]  seg_all;
  logic [7*DIGITS-1:0]  seg_nxt;
  logic                 next_p;
  logic                 prev_p;
  logic                 xfer;

  hyb_debounce #(.DEBOUNCE(DEBOUNCE)) u_next (.clk(clk), .rst(rst), .btn(btn_next), .press(next_p));
  hyb_debounce #(.DEBOUNCE(DEBOUNCE)) u_prev (.clk(clk), .rst(rst), .btn(btn_prev), .press(prev_p));

  assign xfer = in_valid & in_ready;

  always_comb begin
    seg_nxt = '1;
    for (int d = 0; d < DIGITS; d++) begin
      if (state == LOADED && disp)
        seg_nxt[7*d +: 7] = hex2seg(hold[4*(int'(page)*DIGITS + d) +: 4]);
      else if ((state == LOADED || disp) && d < 8)
        seg_nxt[7*d +: 7] = HYB_BANNER[3'(d)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      loaded   <= 1'b0;
      page     <= '0;
      in_ready <= 1'b1;
      // NOTE: the holding register is a plain register, so clearing it on reset is cheap.
      hold     <= '0;
      seg_all  <= '1;
    end else begin
      seg_all  <= seg_nxt;
      in_ready <= (xfer || state == LOADED) ? ~disp : 1'b1;
      if (xfer) begin
        state  <= LOADED;
        loaded <= 1'b1;
        hold   <= in_data;
        page   <= '0;
      end else if (state == LOADED && PAGES > 1 && (next_p ^ prev_p)) begin
        if (next_p)
          page <= (page == PAGE_W'(PAGES - 1)) ? '0 : page + 1'b1;
        else
          page <= (page == '0) ? PAGE_W'(PAGES - 1) : page - 1'b1;
      end
    end
  end

`ifdef HYB_SSD_SCAN_EN
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0] div_cnt;
  logic [IDX_W-1:0] idx;

  // The digit code and its anode are registered together so they never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
      an_out  <= ~DIGITS'(1);
      seg_out <= SEG_BLANK;
    end else begin
      an_out  <= ~(DIGITS'(1) << idx);
      seg_out <= seg_all[7*idx +: 7];
      if (div_cnt == CNT_W'(SCAN_DIV - 1)) begin
        div_cnt <= '0;
        idx     <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end
`else
  assign seg_out = seg_all;
`endif

endmodule

// File: tb/tb_hyb_ssd_pager.sv
// Self-checking bench for hyb_ssd_pager: directed paging scenarios plus randomized traffic against a behavioural model.
module tb_hyb_ssd_pager;

  localparam int DATA_W = 128;
  localparam int DIGITS = 8;
  localparam int DEB    = 4;
  localparam int PAGES  = 4;
  localparam int SDIV   = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready;
  logic         disp = 1'b1;
  logic         btn_next = 1'b0;
  logic         btn_prev = 1'b0;
`ifdef HYB_SSD_SCAN_EN
  logic [6:0]   seg_out;
  logic [7:0]   an_out;
`else
  logic [55:0]  seg_out;
`endif
  logic [1:0]   page;
  logic         loaded;

  always #5 clk = ~clk;

  hyb_ssd_pager #(
    .DATA_W(DATA_W), .DIGITS(DIGITS), .DEBOUNCE(DEB)
`ifdef HYB_SSD_SCAN_EN
    , .SCAN_DIV(SDIV)
`endif
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .disp(disp), .btn_next(btn_next), .btn_prev(btn_prev), .seg_out(seg_out),
`ifdef HYB_SSD_SCAN_EN
    .an_out(an_out),
`endif
    .page(page), .loaded(loaded)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] hex_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [6:0] ban_tab [8] = '{7'b0100100, 7'b0110000, 7'b0001000, 7'b1001111,
                              7'b1111110, 7'b0010010, 7'b0111000, 7'b1100000};

  bit           m_loaded, m_ready, chk_en;
  logic [127:0] m_hold;
  int           m_page;
  logic [55:0]  m_seg;
  bit           ring [2][64];
  int           m_cyc;
  bit           m_lvl [2];
  bit           m_pend [2];
  int           m_idx, m_cnt;
  logic [6:0]   m_sseg;
  logic [7:0]   m_an;

  function automatic logic [55:0] calc_seg(bit ld, logic [127:0] h, int p, bit ds);
    logic [55:0] r;
    for (int d = 0; d < DIGITS; d++) begin
      logic [127:0] sh;
      sh = h >> (4 * (p * DIGITS + d));
      if (ld && ds)       r[7*d +: 7] = hex_tab[sh[3:0]];
      else if (ld || ds)  r[7*d +: 7] = ban_tab[d];
      else                r[7*d +: 7] = 7'h7F;
    end
    return r;
  endfunction

  // Synchronised sample seen by the debouncer; history before reset reads as released.
  function automatic bit sample(int b, int i);
    return (i < 0) ? 1'b0 : ring[b][i % 64];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_loaded = 0; m_ready = 1; m_hold = '0; m_page = 0; m_seg = '1;
      m_cyc = 0; m_lvl = '{0, 0}; m_pend = '{0, 0};
      m_idx = 0; m_cnt = 0; m_sseg = 7'h7F; m_an = 8'hFE;
      chk_en = 1;
    end else begin
      bit xfer, raw [2];
      xfer = in_valid && m_ready;
      // scan outputs take the digit code registered on the previous edge
      m_sseg = m_seg[7*m_idx +: 7];
      m_an   = ~(8'd1 << m_idx);
      if (m_cnt == SDIV - 1) begin m_cnt = 0; m_idx = (m_idx + 1) % DIGITS; end
      else m_cnt++;
      m_seg = calc_seg(m_loaded, m_hold, m_page, disp);
      if (xfer) begin
        m_hold = in_data; m_page = 0; m_loaded = 1;
      end else if (m_loaded && (m_pend[0] != m_pend[1])) begin
        m_page = m_pend[0] ? (m_page + 1) % PAGES : (m_page + PAGES - 1) % PAGES;
      end
      m_ready = m_loaded ? !disp : 1'b1;
      raw[0] = btn_next; raw[1] = btn_prev;
      for (int b = 0; b < 2; b++) begin
        bit all_diff;
        ring[b][m_cyc % 64] = raw[b];
        all_diff = 1;
        for (int j = 0; j < DEB; j++)
          if (sample(b, m_cyc - 2 - j) == m_lvl[b]) all_diff = 0;
        m_pend[b] = 0;
        if (all_diff) begin
          m_lvl[b] = !m_lvl[b];
          m_pend[b] = m_lvl[b];
        end
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("page", page, m_page);
      check("in_ready", in_ready, m_ready);
      check("loaded", loaded, m_loaded);
`ifdef HYB_SSD_SCAN_EN
      check("seg_scan", seg_out, m_sseg);
      check("an_out", an_out, m_an);
`else
      check("seg_out", seg_out, m_seg);
`endif
    end
  end

  // ---------------- directed + random stimulus ----------------
  localparam logic [127:0] D1 = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [55:0] BANNER = {7'b1100000, 7'b0111000, 7'b0010010, 7'b1111110,
                                    7'b1001111, 7'b0001000, 7'b0110000, 7'b0100100};
  localparam logic [55:0] PAGE0 = {7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
                                   7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001};
  localparam logic [55:0] PAGE1 = {7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
                                   7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000};
  localparam logic [55:0] PAGE3 = {7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                   7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_seg(input string name, input logic [55:0] lit);
`ifdef HYB_SSD_SCAN_EN
    check(name, m_seg, lit);
`else
    check(name, seg_out, lit);
`endif
  endtask

  task automatic press(input bit nx, input bit pv);
    btn_next = nx; btn_prev = pv;
    cycles(3 * DEB);
    btn_next = 0; btn_prev = 0;
    cycles(3 * DEB);
  endtask

  initial begin
    cycles(3);
    rst = 0;
    cycles(2);
    check_seg("banner_after_reset", BANNER);
    check("reset_page", page, 0);
    check("reset_ready", in_ready, 1);
    check("reset_loaded", loaded, 0);
`ifdef HYB_SSD_SCAN_EN
    check("scan_an_walk", an_out, ~(8'd1 << ((5 / SDIV) % 8)));
`endif

    disp = 0; in_data = D1; in_valid = 1;
    cycles(1);
    check("loaded_after_capture", loaded, 1);
    in_valid = 0; disp = 1;
    cycles(2);
    check_seg("page0_digits", PAGE0);

    press(1, 0); check("next_to_1", page, 1);
    press(1, 0); check("next_to_2", page, 2);
    press(1, 0); check("next_to_3", page, 3);
    check_seg("page3_digits", PAGE3);
    press(1, 0); check("next_wrap_0", page, 0);
    press(0, 1); check("prev_wrap_3", page, 3);

    for (int t = 0; t < 5; t++) begin
      btn_next = ~btn_next;
      cycles(DEB / 2);
    end
    press(1, 0); check("bounce_one_step", page, 0);
    press(1, 1); check("both_no_change", page, 0);
    press(1, 0); check("page_before_lock", page, 1);

    in_valid = 1; in_data = ~D1;
    cycles(5);
    check("ready_low_while_shown", in_ready, 0);
    check_seg("display_frozen", PAGE1);
    disp = 0;
    cycles(3);
    check("capture_resets_page", page, 0);
    in_valid = 0; disp = 1;
    cycles(2);
    check_seg("new_word_page0", calc_seg(1, ~D1, 0, 1));

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) btn_next = ~btn_next;
      if ($urandom_range(0, 5) == 0) btn_prev = ~btn_prev;
      if ($urandom_range(0, 19) == 0) disp = ~disp;
      in_valid = ($urandom_range(0, 7) == 0);
      in_data = {$urandom, $urandom, $urandom, $urandom};
      rst = ($urandom_range(0, 299) == 0);
      cycles(1);
    end
    rst = 0;
    cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hyb_ssd_pager.md
Name: hyb_ssd_pager

Overview:
- Registered, parametrised display pager for the hybrid cipher output.
- Captures a DATA_W-bit cipher result through a valid/ready handshake and splits it into PAGES = DATA_W/(4*DIGITS) pages of DIGITS hex digits.
- The user steps through pages with debounced next/prev buttons. A banner is shown while the display is disabled or nothing has been captured.
- Sits between the AES/Blowfish datapath and the board seven-segment digits.

Parameters:
- DATA_W, 128, captured word width; must be a multiple of 4*DIGITS.
- DIGITS, 8, seven-segment digits driven per page.
- DEBOUNCE, 16, consecutive stable cycles required before a button level is accepted; must be at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  cipher result valid.
- in_data  in  DATA_W  cipher result.
- in_ready  out  1  pager can accept in_data.
- disp  in  1  display enable (level).
- btn_next  in  1  raw, asynchronous next-page button.
- btn_prev  in  1  raw, asynchronous previous-page button.
- seg_out  out  7*DIGITS  digit d drives seg_out[7d+6:7d].
  - Bit order is {a,b,c,d,e,f,g}, MSB first, active-low.
- page  out  clog2(PAGES) (minimum 1)  current page index.
- loaded  out  1  a word has been captured since reset.

Behaviour:
- All outputs are registered. Every state change takes effect on the clk edge. rst has priority over every other input.
- Reset values:
  - state = EMPTY, loaded = 0, page = 0, in_ready = 1.
  - seg_out = all ones (all digits blank); holding register = 0.
  - Debouncers cleared to released.
- FSM has two states, EMPTY and LOADED.
  - EMPTY: in_ready = 1. seg_out shows the banner if disp = 1, otherwise blank.
  - EMPTY -> LOADED on in_valid & in_ready.
  - LOADED: in_ready = ~disp, so the captured word is frozen while it is displayed.
  - LOADED: a handshake overwrites the holding register and forces page = 0.
  - LOADED stays LOADED until rst.
- Handshake:
  - Transfer occurs on the edge where in_valid & in_ready.
  - New digits appear on seg_out one cycle after the transfer edge.
  - in_data is ignored when in_ready = 0. in_valid may stay high without penalty.
- Display mapping in LOADED with disp = 1:
  - Digit d of page p shows the nibble at bits [4*(p*DIGITS+d)+3 : 4*(p*DIGITS+d)].
  - Nibbles are hex-decoded: 0 -> 0000001, 8 -> 0000000, A -> 0001000, F -> 0111000.
- disp = 0 in LOADED: seg_out shows the banner.
- Banner: the package constant HYB_BANNER holds 8 codes.
  - Digit d < 8 takes HYB_BANNER[d]; digits 8 and above are blank.
  - DIGITS < 8 uses entries 0..DIGITS-1.
- Buttons:
  - Each button passes a 2-flop synchroniser, then a stable counter.
  - The debounced level changes only after DEBOUNCE consecutive equal samples.
  - A one-cycle press pulse is emitted on the debounced rising edge.
- Paging:
  - Next pulse: page = (page == PAGES-1) ? 0 : page+1.
  - Prev pulse: page = (page == 0) ? PAGES-1 : page-1.
  - Next and prev pulses in the same cycle: no change.
  - Pulses are ignored in EMPTY.
  - A capture in the same cycle as a pulse: page = 0 (capture wins).
  - PAGES = 1: page is constantly 0.
- A held button produces exactly one step. Releases and glitches shorter than DEBOUNCE produce no step.
- rst mid-bounce discards partial counts.

Optional Feature:
- Macro: HYB_SSD_SCAN_EN.
- Defined:
  - Adds parameter SCAN_DIV (default 50000) and output an_out[DIGITS-1:0], one-hot, active-low.
  - seg_out narrows to 7 bits and is time-multiplexed.
  - A divider advances the active digit every SCAN_DIV cycles, in order 0..DIGITS-1 with wrap.
  - seg_out carries that digit's code, registered alongside an_out.
  - Reset: an_out selects digit 0 (value ~1); seg_out is blank.
- Undefined: static parallel outputs as described above; no an_out.

Decomposition:
- Package hyb_ssd_pkg holds:
  - HYB_BANNER (8 x 7-bit codes: 1100000, 0111000, 0010010, 1111110, 1001111, 0001000, 0110000, 0100100 for digits 7..0).
  - SEG_BLANK = 7'h7F.
  - Hex-to-segment function hex2seg.
  - State enum {EMPTY, LOADED}.
- One sub-module: hyb_debounce (synchroniser, stable counter, rise pulse), instantiated per button.

Test Plan:
- Reset, disp = 1 -> seg_out = banner, page = 0, in_ready = 1, loaded = 0.
- disp = 0, in_data = 128'h0123456789ABCDEFFEDCBA9876543210 with in_valid -> loaded = 1 one cycle later. Then disp = 1 -> page 0 digits 7..0 show 7,6,5,4,3,2,1,0.
- Four next presses, each held 3*DEBOUNCE cycles:
  - Pages step 1, 2, 3, then wrap to 0.
  - Page 3 shows 0,1,2,3,4,5,6,7.
  - One prev press from 0 -> page 3.
- Bounce btn_next for 5 toggles, each shorter than DEBOUNCE, then hold -> exactly one step. Next and prev pressed together -> page unchanged.
- LOADED with disp = 1 and new in_valid -> in_ready = 0, display unchanged. Drop disp -> capture occurs, page = 0.
- HYB_SSD_SCAN_EN defined, SCAN_DIV = 4, DIGITS = 8 -> an_out walks ~8'h01, ~8'h02 ... every 4 cycles, wraps after digit 7, and seg_out matches the selected digit.
